// File: rtl/filter_seq_pkg.sv
// ---------------------------------------------------------------------------
// filter_seq_pkg
// Shared definitions for the 3x3 window sequencer:
//   state_t      - sequencer state encoding
//   WIN_ENTRY_W  - bits per window entry ({centre valid, pixel[7:0]})
//   WIN_SIZE     - window edge length (3x3)
//   win_off()    - bit offset of window entry (r,c) inside the flat win bus
// ---------------------------------------------------------------------------
package filter_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int WIN_ENTRY_W = 9;
  localparam int WIN_SIZE    = 3;

  // Row r, column c; row 0 is the oldest line, column 0 the oldest pixel.
  function automatic int win_off(input int r, input int c);
    return (r * WIN_SIZE + c) * WIN_ENTRY_W;
  endfunction

endpackage

// File: rtl/filter_line_buffer.sv
// ---------------------------------------------------------------------------
// filter_line_buffer
// Two MAX_WIDTH x 8 line stores forming a two-line delay indexed by column.
// Reads are combinational at addr; on we the older line takes the newer
// line's pixel and the newer line takes wr_data (read-before-write at the
// same address).
// Ports:
//   clk      clock
//   we       write enable (one accepted pixel)
//   addr     column address
//   wr_data  incoming pixel
//   rd_row0  pixel two lines above (oldest)
//   rd_row1  pixel one line above
// ---------------------------------------------------------------------------
module filter_line_buffer
  import filter_seq_pkg::*;
#(
  parameter int MAX_WIDTH = 640,
  parameter int AW        = $clog2(MAX_WIDTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wr_data,
  output logic [7:0]    rd_row0,
  output logic [7:0]    rd_row1
);

  logic [7:0] line0 [MAX_WIDTH];  // most recent line
  logic [7:0] line1 [MAX_WIDTH];  // line before that

  assign rd_row0 = line1[addr];
  assign rd_row1 = line0[addr];

  // NOTE: the stores have no reset; every location is written before it can
  // reach a valid window, so clearing them would only cost logic.
  // NOTE: non-blocking assignments make line1 take line0's old value, which
  // is exactly the read-before-write shift we want.
  always_ff @(posedge clk) begin
    if (we) begin
      line1[addr] <= line0[addr];
      line0[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/filter_window_seq.sv
// ---------------------------------------------------------------------------
// filter_window_seq
// Frame sequencer and 3x3 window generator feeding a 3x3 filter stage.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         one-cycle frame start; cfg_width/cfg_height sampled with it
//   in_valid/in_ready/in_pixel  raster pixel stream
//   win           9 entries {centre valid, pixel}, entry (r,c) at win_off(r,c)
//   op_reflesh    one-cycle refresh to the filter stage at frame start
//   op_out        filter stage result {valid, pixel}
//   out_valid/out_pixel  op_out registered one cycle
//   busy          frame in progress (RUN, DRAIN, DONE)
//   done          one-cycle frame-complete pulse
//   err           one-cycle pulse: rejected start or drain timeout
// ---------------------------------------------------------------------------
module filter_window_seq
  import filter_seq_pkg::*;
#(
  parameter int MAX_WIDTH = 640,
  parameter int W_BITS    = 10,
  parameter int H_BITS    = 10,
  parameter int OP_LAT    = 4,
  parameter int DRAIN_MAX = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [W_BITS-1:0] cfg_width,
  input  logic [H_BITS-1:0] cfg_height,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_pixel,
  output logic [80:0]       win,
  output logic              op_reflesh,
  input  logic [8:0]        op_out,
  output logic              out_valid,
  output logic [7:0]        out_pixel,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int LB_AW = $clog2(MAX_WIDTH);
  localparam int CNT_W = W_BITS + H_BITS;
  // A timeout shorter than the stage's own latency would abort every frame.
  localparam int DRAIN_LIMIT = (DRAIN_MAX > OP_LAT + 1) ? DRAIN_MAX : OP_LAT + 2;
  localparam int DC_W  = $clog2(DRAIN_LIMIT + 1);

  state_t             state, state_nx;
  logic [W_BITS-1:0]  cfg_w, col;
  logic [H_BITS-1:0]  cfg_h, row;
  logic [CNT_W-1:0]   out_cnt, target;
  logic [DC_W-1:0]    drain_cnt;
  logic [7:0]         win_px [WIN_SIZE][WIN_SIZE];
  logic               win_vld;
  logic               accept, cfg_ok, last_col, last_row;
  logic               start_ok, start_bad, timeout;
  logic [7:0]         lb_row0, lb_row1;

  assign in_ready = (state == ST_RUN);
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign accept   = in_valid && in_ready;

  assign cfg_ok   = (cfg_width >= W_BITS'(3)) && (32'(cfg_width) <= MAX_WIDTH) &&
                    (cfg_height >= H_BITS'(3));
  assign last_col = (col == cfg_w - W_BITS'(1));
  assign last_row = (row == cfg_h - H_BITS'(1));

  filter_line_buffer #(.MAX_WIDTH(MAX_WIDTH), .AW(LB_AW)) u_line_buffer (
    .clk     (clk),
    .we      (accept),
    .addr    (LB_AW'(col)),
    .wr_data (in_pixel),
    .rd_row0 (lb_row0),
    .rd_row1 (lb_row1)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no branch can
    // leave one unassigned and infer a latch.
    state_nx  = state;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    timeout   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            start_ok = 1'b1;
            state_nx = ST_RUN;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (accept && last_col && last_row) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (out_cnt == target) begin
          state_nx = ST_DONE;
        end else if (drain_cnt == DC_W'(DRAIN_LIMIT - 1)) begin
          timeout  = 1'b1;
          state_nx = ST_DONE;
        end
      end
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_w      <= '0;
      cfg_h      <= '0;
      col        <= '0;
      row        <= '0;
      out_cnt    <= '0;
      target     <= '0;
      drain_cnt  <= '0;
      win_vld    <= 1'b0;
      op_reflesh <= 1'b0;
      err        <= 1'b0;
      out_valid  <= 1'b0;
      out_pixel  <= '0;
      for (int r = 0; r < WIN_SIZE; r++)
        for (int c = 0; c < WIN_SIZE; c++)
          win_px[r][c] <= '0;
    end else begin
      op_reflesh <= start_ok;
      err        <= start_bad | timeout;
      out_valid  <= op_out[8];
      out_pixel  <= op_out[7:0];
      // Only a pixel whose full neighbourhood lies inside the frame makes a
      // valid centre; stale columns after a line wrap sit behind col < 2.
      win_vld    <= accept && (row >= H_BITS'(2)) && (col >= W_BITS'(2));

      if (start_ok) begin
        cfg_w     <= cfg_width;
        cfg_h     <= cfg_height;
        col       <= '0;
        row       <= '0;
        out_cnt   <= '0;
        drain_cnt <= '0;
        target    <= CNT_W'(cfg_width - W_BITS'(2)) * CNT_W'(cfg_height - H_BITS'(2));
      end

      if (accept) begin
        for (int r = 0; r < WIN_SIZE; r++) begin
          win_px[r][0] <= win_px[r][1];
          win_px[r][1] <= win_px[r][2];
        end
        win_px[0][2] <= lb_row0;
        win_px[1][2] <= lb_row1;
        win_px[2][2] <= in_pixel;
        if (last_col) begin
          col <= '0;
          row <= row + H_BITS'(1);
        end else begin
          col <= col + W_BITS'(1);
        end
      end

      if ((state == ST_RUN || state == ST_DRAIN) && op_out[8])
        out_cnt <= out_cnt + CNT_W'(1);

      if (state == ST_DRAIN)
        drain_cnt <= drain_cnt + DC_W'(1);
    end
  end

  always_comb begin
    win = '0;
    for (int r = 0; r < WIN_SIZE; r++)
      for (int c = 0; c < WIN_SIZE; c++)
        win[win_off(r, c) +: WIN_ENTRY_W] = {win_vld, win_px[r][c]};
  end

endmodule

// File: tb/tb_filter_window_seq.sv
// ---------------------------------------------------------------------------
// tb_filter_window_seq
// Self-checking bench for filter_window_seq. A reference model tracks the
// accepted pixel index of each frame, derives (row,col) arithmetically, and
// predicts each window from a frame array and each filter output as the
// centre pixel. A stub filter stage returns the window centre after OP_LAT.
// ---------------------------------------------------------------------------
module tb_filter_window_seq;
  import filter_seq_pkg::*;

  localparam int MAX_WIDTH = 640;
  localparam int W_BITS    = 10;
  localparam int H_BITS    = 10;
  localparam int OP_LAT    = 4;
  localparam int DRAIN_MAX = 64;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [9:0]  cfg_width, cfg_height;
  logic        in_valid, in_ready;
  logic [7:0]  in_pixel;
  logic [80:0] win;
  logic        op_reflesh;
  logic [8:0]  op_out;
  logic        out_valid;
  logic [7:0]  out_pixel;
  logic        busy, done, err;

  always #5 clk = ~clk;

  filter_window_seq #(
    .MAX_WIDTH(MAX_WIDTH), .W_BITS(W_BITS), .H_BITS(H_BITS),
    .OP_LAT(OP_LAT), .DRAIN_MAX(DRAIN_MAX)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .win(win), .op_reflesh(op_reflesh), .op_out(op_out),
    .out_valid(out_valid), .out_pixel(out_pixel),
    .busy(busy), .done(done), .err(err)
  );

  // Stub filter stage: centre entry delayed OP_LAT cycles, flushed on refresh.
  bit         stub_en;
  logic [8:0] pipe [OP_LAT];
  always @(posedge clk) begin
    if (rst || op_reflesh) begin
      for (int i = 0; i < OP_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= win[win_off(1, 1) +: 9];
      for (int i = 1; i < OP_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign op_out = stub_en ? pipe[OP_LAT-1] : 9'd0;

  // Bookkeeping
  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  frame_mem [1024];
  int          fw = 3, fh = 3;
  int          acc_cnt, pend_r, pend_c;
  bit          pend_vld;
  logic [7:0]  exp_q [$];
  logic [7:0]  got_q [$];
  int          n_win, n_done, n_err, cyc, last_acc_cyc, err_cyc, done_cyc;

  typedef struct {
    int w;
    int h;
    bit exp_err;
  } start_vec_t;
  start_vec_t tbl [8];

  task automatic check(input string name, input logic [80:0] act, input logic [80:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s", name);
  endtask

  // One clock: predict from pre-edge inputs, then compare #1 after the edge.
  task automatic step(output bit acc);
    logic [80:0] exp_win;
    logic [8:0]  vld_bits;
    acc = 1'b0;
    if (rst) begin
      pend_vld = 1'b0;
      acc_cnt  = 0;
      exp_q.delete();
    end else begin
      if (op_reflesh) acc_cnt = 0;
      pend_vld = 1'b0;
      if (in_valid && in_ready) begin
        acc      = 1'b1;
        pend_r   = acc_cnt / fw;
        pend_c   = acc_cnt % fw;
        pend_vld = (pend_r >= 2) && (pend_c >= 2);
        if (pend_vld) exp_q.push_back(frame_mem[(pend_r - 1) * fw + pend_c - 1]);
        acc_cnt++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (acc)  last_acc_cyc = cyc;
    if (done) begin n_done++; done_cyc = cyc; end
    if (err)  begin n_err++;  err_cyc  = cyc; end
    if (pend_vld) begin
      n_win++;
      exp_win = '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          exp_win[win_off(i, j) +: 9] =
            {1'b1, frame_mem[(pend_r - 2 + i) * fw + (pend_c - 2 + j)]};
      check("win", win, exp_win);
    end else begin
      for (int k = 0; k < 9; k++) vld_bits[k] = win[k * 9 + 8];
      check("win_vld_idle", 81'(vld_bits), 81'(0));
    end
    if (out_valid) begin
      if (exp_q.size() == 0) fail_now("out_unexpected");
      else check("out_pixel", 81'(out_pixel), 81'(exp_q.pop_front()));
      got_q.push_back(out_pixel);
    end
  endtask

  // pmode: 0 = row*16+col, 1 = all 0x7F, 2 = random
  // vmode: 0 = valid held, 1 = toggle, 2 = random
  task automatic run_frame(input int w, input int h, input int pmode, input int vmode,
                           input bit stub, input int abort_at, input bit mid_start);
    bit a;
    bit ms_done;
    int idx, k, guard;
    fw = w;
    fh = h;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        frame_mem[r * w + c] = (pmode == 0) ? 8'((r * 16 + c) & 8'hFF) :
                               (pmode == 1) ? 8'h7F : 8'($urandom_range(0, 255));
    stub_en = stub;
    exp_q.delete();
    got_q.delete();
    n_win = 0; n_done = 0; n_err = 0; err_cyc = -1; done_cyc = -1;
    start = 1'b1;
    cfg_width  = 10'(w);
    cfg_height = 10'(h);
    step(a);
    start = 1'b0;
    check("reflesh_pulse", 81'(op_reflesh), 81'(1));
    check("busy_run", 81'(busy), 81'(1));
    idx = 0; k = 0; guard = 0; ms_done = 1'b0;
    while (idx < w * h && guard < 5000) begin
      case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = (k % 2 == 0);
        default: in_valid = ($urandom_range(0, 3) != 0);
      endcase
      in_pixel = frame_mem[idx];
      if (mid_start && idx == 5 && !ms_done) begin
        start = 1'b1; cfg_width = 10'd7; cfg_height = 10'd7; ms_done = 1'b1;
      end
      step(a);
      start = 1'b0;
      k++; guard++;
      if (a) idx++;
      if (abort_at >= 0 && idx == abort_at) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    if (idx < w * h) fail_now("feed_timeout");
    guard = 0;
    while (n_done == 0 && guard < 300) begin
      step(a);
      guard++;
    end
    if (n_done == 0) fail_now("done_timeout");
    step(a);
    check("idle_after_done", 81'(busy), 81'(0));
    check("single_done", 81'(n_done), 81'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    int w, h;
    rst = 1'b1; start = 1'b0; cfg_width = '0; cfg_height = '0;
    in_valid = 1'b0; in_pixel = '0; stub_en = 1'b1; cyc = 0;
    step(a);
    step(a);
    check("reset_ctrl", 81'({in_ready, busy, done, err, op_reflesh, out_valid, out_pixel}), 81'(0));
    check("reset_win", win, 81'(0));
    rst = 1'b0;
    step(a);

    // Start acceptance table
    tbl[0] = '{2, 3, 1'b1};
    tbl[1] = '{3, 2, 1'b1};
    tbl[2] = '{0, 0, 1'b1};
    tbl[3] = '{641, 4, 1'b1};
    tbl[4] = '{1023, 1023, 1'b1};
    tbl[5] = '{3, 3, 1'b0};
    tbl[6] = '{640, 3, 1'b0};
    tbl[7] = '{5, 1023, 1'b0};
    for (int i = 0; i < 8; i++) begin
      start = 1'b1;
      cfg_width  = 10'(tbl[i].w);
      cfg_height = 10'(tbl[i].h);
      step(a);
      start = 1'b0;
      check("start_err",     81'(err),        81'(tbl[i].exp_err));
      check("start_busy",    81'(busy),       81'(!tbl[i].exp_err));
      check("start_reflesh", 81'(op_reflesh), 81'(!tbl[i].exp_err));
      check("start_ready",   81'(in_ready),   81'(!tbl[i].exp_err));
      step(a);
      check("err_one_cycle", 81'(err), 81'(0));
      if (busy) begin
        rst = 1'b1;
        step(a);
        rst = 1'b0;
        check("abort_idle", 81'({busy, in_ready, done, err}), 81'(0));
      end
    end

    // 4x3 pattern frame, valid held
    run_frame(4, 3, 0, 0, 1'b1, -1, 1'b0);
    check("t1_windows", 81'(n_win), 81'(2));
    check("t1_outputs", 81'(got_q.size()), 81'(2));
    if (got_q.size() == 2) begin
      check("t1_out0", 81'(got_q[0]), 81'(8'h11));
      check("t1_out1", 81'(got_q[1]), 81'(8'h12));
    end
    check("t1_no_err", 81'(n_err), 81'(0));

    // Same frame, in_valid toggled
    run_frame(4, 3, 0, 1, 1'b1, -1, 1'b0);
    check("t2_windows", 81'(n_win), 81'(2));
    check("t2_outputs", 81'(got_q.size()), 81'(2));
    if (got_q.size() == 2) begin
      check("t2_out0", 81'(got_q[0]), 81'(8'h11));
      check("t2_out1", 81'(got_q[1]), 81'(8'h12));
    end

    // Mid-frame reset after 12 accepted pixels, then a 3x3 0x7F frame
    run_frame(5, 5, 2, 0, 1'b1, 12, 1'b0);
    rst = 1'b1;
    step(a);
    rst = 1'b0;
    check("t4_rst_ctrl", 81'({in_ready, busy, done, err, op_reflesh, out_valid, out_pixel}), 81'(0));
    check("t4_rst_win", win, 81'(0));
    check("t4_no_done", 81'(n_done), 81'(0));
    run_frame(3, 3, 1, 0, 1'b1, -1, 1'b0);
    check("t4_windows", 81'(n_win), 81'(1));
    check("t4_outputs", 81'(got_q.size()), 81'(1));
    if (got_q.size() == 1) check("t4_out0", 81'(got_q[0]), 81'(8'h7F));
    check("t4_no_err", 81'(n_err), 81'(0));

    // Stage never answers: drain timeout
    run_frame(3, 3, 2, 0, 1'b0, -1, 1'b0);
    check("t5_err_count", 81'(n_err), 81'(1));
    check("t5_err_time", 81'(err_cyc - last_acc_cyc), 81'(DRAIN_MAX));
    check("t5_done_with_err", 81'(done_cyc), 81'(err_cyc));
    check("t5_outputs", 81'(got_q.size()), 81'(0));
    stub_en = 1'b1;

    // start during RUN is ignored
    run_frame(4, 4, 0, 0, 1'b1, -1, 1'b1);
    check("t6_outputs", 81'(got_q.size()), 81'(4));
    check("t6_no_err", 81'(n_err), 81'(0));

    // Random frames and random valid pattern
    for (int t = 0; t < 4; t++) begin
      w = $urandom_range(3, 8);
      h = $urandom_range(3, 6);
      run_frame(w, h, 2, 2, 1'b1, -1, 1'b0);
      check("rnd_windows", 81'(n_win), 81'((w - 2) * (h - 2)));
      check("rnd_outputs", 81'(got_q.size()), 81'((w - 2) * (h - 2)));
      check("rnd_no_err", 81'(n_err), 81'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/filter_window_seq.md
Name: filter_window_seq

Overview:
- Frame sequencer and 3x3 window generator in front of the 3x3 filter operation stage.
- Accepts a raster pixel stream (valid/ready) for a frame of configurable size.
- Builds the 3x3 neighbourhood with two line buffers, flags the centre as valid only when the full neighbourhood lies inside the frame, and pulses the stage's refresh input at frame start.
- Counts the filtered outputs returned by the stage and signals frame completion.

Parameters:
MAX_WIDTH, 640, maximum line length in pixels (line buffer depth)
W_BITS, 10, width of the column counter and cfg_width
H_BITS, 10, width of the row counter and cfg_height
OP_LAT, 4, cycles from window valid to filter output valid
DRAIN_MAX, 64, drain timeout in cycles after the last input

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
start  in  1  one-cycle frame start command
cfg_width  in  W_BITS  frame width; sampled on an accepted start
cfg_height  in  H_BITS  frame height; sampled on an accepted start
in_valid  in  1  input pixel valid
in_ready  out  1  sequencer accepts a pixel
in_pixel  in  8  input pixel, raster order
win  out  81  window; entry (r,c) at bits [(r*3+c)*9 +: 9]; bit 8 = centre valid, bits 7:0 = pixel
op_reflesh  out  1  refresh pulse to the filter stage
op_out  in  9  filter stage output; bit 8 = valid, bits 7:0 = pixel
out_valid  out  1  registered copy of op_out[8]
out_pixel  out  8  registered copy of op_out[7:0]
busy  out  1  frame in progress
done  out  1  one-cycle frame-complete pulse
err  out  1  one-cycle pulse: start rejected or drain timeout

Behaviour:
- Reset: state IDLE; all outputs 0; win 0; counters 0. Line buffer contents are don't-care.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - in_ready=0.
  - start with cfg_width in 3..MAX_WIDTH and cfg_height >= 3: latch the config, clear counters, pulse op_reflesh for 1 cycle, go to RUN.
  - Any other start: err pulse, stay in IDLE.
- RUN:
  - in_ready=1. A pixel is accepted when in_valid && in_ready.
  - On acceptance:
    - Shift window columns left.
    - New column = {linebuf1[col], linebuf0[col], in_pixel} for rows 0,1,2 (row 0 oldest).
    - Write linebuf1[col] <= linebuf0[col] and linebuf0[col] <= in_pixel.
    - Advance col; wrap to 0 at W-1 and increment row.
  - The window is registered: it updates the cycle after acceptance.
  - Bit 8 of all nine entries = 1 for exactly one cycle when the accepted pixel had row >= 2 and col >= 2; otherwise 0.
  - Window columns are not cleared at line wrap. Stale columns only appear while col < 2, and those windows carry valid=0.
  - No acceptance: window pixels hold, valid=0.
  - Acceptance of pixel (H-1, W-1): in_ready drops next cycle; go to DRAIN.
- Output path:
  - out_valid/out_pixel are op_out registered by 1 cycle.
  - The output counter increments on every op_out[8], and only in RUN or DRAIN.
- DRAIN:
  - When the output count reaches (W-2)*(H-2), go to DONE.
  - If DRAIN_MAX cycles elapse first: err pulse, then DONE.
- DONE: done=1 for 1 cycle, then IDLE.
- busy=1 in RUN, DRAIN and DONE.
- start while busy is ignored (no err).
- Latency: in_pixel accepted at cycle t gives win valid at t+1 and the filter output at t+1+OP_LAT (from the stage).
- rst mid-frame: immediate return to IDLE; no done, no err. The next frame pulses op_reflesh, so stale pipeline contents are discarded.
- Simultaneous final acceptance and output count reaching the target: go to DRAIN, then DONE on the next cycle.

Decomposition:
- Package filter_seq_pkg:
  - state enum.
  - WIN_ENTRY_W=9 and WIN_SIZE=3 constants.
  - Helper function for the win entry offset (r*3+c)*9.
- One sub-module, filter_line_buffer:
  - Two single-port MAX_WIDTH x 8 arrays.
  - Read-before-write at the same address each accept.
  - Combinational read, registered write.

Test Plan:
1. 4x3 frame, pixel = row*16+col, in_valid held high, stub stage = centre pixel delayed OP_LAT.
   - Win valid after pixels (2,2) and (2,3).
   - First window rows = {00,01,02},{10,11,12},{20,21,22}; second = {01,02,03},{11,12,13},{21,22,23}.
   - Out pixels 0x11 then 0x12; done pulses; 2 outputs counted.
2. Same frame, in_valid toggled 1/0 every cycle.
   - Identical window contents and outputs.
   - Win valid never asserted on non-accept cycles.
3. start with cfg_width=2 or cfg_height=2 → err=1 for 1 cycle, state stays IDLE, in_ready=0, no op_reflesh.
4. 5x5 frame, rst asserted after 12 accepted pixels.
   - All outputs 0 next cycle.
   - A new 3x3 frame of all-0x7F then produces op_reflesh, exactly 1 window (all 0x7F), 1 output, and done.
5. Stub stage never returns valid on a 3x3 frame → err pulse exactly DRAIN_MAX cycles after the last accept, then done, then IDLE.
6. start pulsed during RUN of a 4x4 frame → ignored: config unchanged, 4 outputs, a single done.
